// File: rtl/nw_pkg.sv
// Shared types and constants for the alignment grid and its traceback formatter.
package nw_pkg;

  typedef enum logic [1:0] {
    OP_MATCH    = 2'd0,
    OP_MISMATCH = 2'd1,
    OP_GAP      = 2'd2,
    OP_BAD      = 2'd3
  } op_t;

  localparam logic [1:0] TOP_DIR    = 2'b00;
  localparam logic [1:0] LEFT_DIR   = 2'b01;
  localparam logic [1:0] CORNER_DIR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT,
    ST_DONE
  } state_t;

  localparam int DEFAULT_MATCH    = 1;
  localparam int DEFAULT_MISMATCH = -1;
  localparam int DEFAULT_INDEL    = -1;

endpackage

// File: rtl/traceback_formatter_if.sv
// Aligned-column output handshake: one column pair per valid/ready transfer.
interface traceback_formatter_if
  import nw_pkg::*;
#(
  parameter int unsigned CWIDTH = 2
);
  logic              out_valid;
  logic              out_ready;
  logic [CWIDTH-1:0] out_c1;
  logic [CWIDTH-1:0] out_c2;
  logic              out_gap1;
  logic              out_gap2;
  op_t               out_op;
  logic              out_last;

  modport master (
    output out_valid, out_c1, out_c2, out_gap1, out_gap2, out_op, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_c1, out_c2, out_gap1, out_gap2, out_op, out_last,
    output out_ready
  );
endinterface

// File: rtl/coord_stack.sv
// LIFO of traceback coordinates; top of stack is presented combinationally.
module coord_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 19
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNTW-1:0]  cnt;

  assign full  = (cnt == CNTW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign top   = empty ? '0 : mem[AW'(cnt - CNTW'(1))];

  always_ff @(posedge clk) begin
    if (push && !full) mem[AW'(cnt)] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CNTW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CNTW'(1);
    end
  end
endmodule

// File: rtl/traceback_formatter.sv
// Buffers the reverse traceback stream and replays it forward as aligned columns,
// tallying matches, mismatches and indels into a recomputed score.
module traceback_formatter
  import nw_pkg::*;
#(
  parameter int unsigned LENGTH      = 10,
  parameter int unsigned CWIDTH      = 2,
  parameter int unsigned SWIDTH      = 16,
  parameter int unsigned CORD_LENGTH = 8,
  parameter int unsigned DEPTH       = 2 * LENGTH - 1,
  parameter int          MATCH       = DEFAULT_MATCH,
  parameter int          MISMATCH    = DEFAULT_MISMATCH,
  parameter int          INDEL       = DEFAULT_INDEL
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [LENGTH*CWIDTH-1:0]      s1,
  input  logic [LENGTH*CWIDTH-1:0]      s2,
  input  logic                          tb_valid,
  input  logic [2*CORD_LENGTH-1:0]      tb_coord,
  traceback_formatter_if.master         col,
  output logic                          done,
  output logic                          err,
  output logic [CORD_LENGTH:0]          n_match,
  output logic [CORD_LENGTH:0]          n_mismatch,
  output logic [CORD_LENGTH:0]          n_indel,
  output logic signed [SWIDTH-1:0]      score
);
  localparam int unsigned TW   = CORD_LENGTH + 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam logic [2*CORD_LENGTH-1:0] START_COORD =
    {CORD_LENGTH'(LENGTH - 1), CORD_LENGTH'(LENGTH - 1)};

  function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] s,
                                                input logic [CORD_LENGTH-1:0] idx);
    logic [CWIDTH-1:0] ch;
    ch = '0;
    for (int unsigned i = 0; i < LENGTH; i++) begin
      if (idx == CORD_LENGTH'(i)) ch = s[(LENGTH-1-i)*CWIDTH +: CWIDTH];
    end
    return ch;
  endfunction

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
    return (t >= TW'(2 * LENGTH)) ? t : t + TW'(1);
  endfunction

  state_t                   state;
  logic                     first_pop;
  logic [CORD_LENGTH-1:0]   prev_x, prev_y;
  logic                     push, pop, full, empty;
  logic [2*CORD_LENGTH-1:0] stack_top;
  logic [CNTW-1:0]          count;

  logic                     out_valid_q, out_gap1_q, out_gap2_q, out_last_q;
  logic [CWIDTH-1:0]        out_c1_q, out_c2_q;
  op_t                      out_op_q;

  logic                     load, last_xfer;
  logic [CORD_LENGTH-1:0]   cx, cy;
  logic [CWIDTH-1:0]        ch1, ch2, c1_n, c2_n;
  logic                     g1_n, g2_n, dx1, dy1, dxe, dye;
  op_t                      op_n;
  logic signed [SWIDTH-1:0] w_m, w_x, w_i, t_m, t_x, t_i, score_n;

  assign col.out_valid = out_valid_q;
  assign col.out_c1    = out_c1_q;
  assign col.out_c2    = out_c2_q;
  assign col.out_gap1  = out_gap1_q;
  assign col.out_gap2  = out_gap2_q;
  assign col.out_op    = out_op_q;
  assign col.out_last  = out_last_q;

  assign load      = !out_valid_q || col.out_ready;
  assign last_xfer = out_valid_q && col.out_ready && out_last_q;

  coord_stack #(.WIDTH(2 * CORD_LENGTH), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (tb_coord),
    .top   (stack_top),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Stack control; clear outranks any incoming word
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    if (!clear) begin
      case (state)
        ST_IDLE:    push = tb_valid;
        ST_COLLECT: push = tb_valid && !full;
        ST_EMIT:    pop  = load && !empty;
        default:    ;
      endcase
    end
  end

  // Classify the step from the popped entry back to the previously popped one
  always_comb begin
    cx   = stack_top[2*CORD_LENGTH-1:CORD_LENGTH];
    cy   = stack_top[CORD_LENGTH-1:0];
    ch1  = char_at(s1, cy);
    ch2  = char_at(s2, cx);
    dx1  = (TW'(cx) == TW'(prev_x) + TW'(1));
    dy1  = (TW'(cy) == TW'(prev_y) + TW'(1));
    dxe  = (cx == prev_x);
    dye  = (cy == prev_y);
    op_n = OP_BAD;
    c1_n = '0;
    c2_n = '0;
    g1_n = 1'b1;
    g2_n = 1'b1;
    if (first_pop || (dx1 && dy1)) begin
      op_n = (ch1 == ch2) ? OP_MATCH : OP_MISMATCH;
      c1_n = ch1;
      c2_n = ch2;
      g1_n = 1'b0;
      g2_n = 1'b0;
    end else if (dxe && dy1) begin
      op_n = OP_GAP;
      c1_n = ch1;
      g1_n = 1'b0;
    end else if (dx1 && dye) begin
      op_n = OP_GAP;
      c2_n = ch2;
      g2_n = 1'b0;
    end
  end

  always_comb begin
    w_m     = SWIDTH'(MATCH);
    w_x     = SWIDTH'(MISMATCH);
    w_i     = SWIDTH'(INDEL);
    t_m     = $signed(SWIDTH'(n_match));
    t_x     = $signed(SWIDTH'(n_mismatch));
    t_i     = $signed(SWIDTH'(n_indel));
    score_n = w_m * t_m + w_x * t_x + w_i * t_i;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= ST_IDLE;
      first_pop   <= 1'b1;
      prev_x      <= '0;
      prev_y      <= '0;
      out_valid_q <= 1'b0;
      out_c1_q    <= '0;
      out_c2_q    <= '0;
      out_gap1_q  <= 1'b0;
      out_gap2_q  <= 1'b0;
      out_op_q    <= OP_MATCH;
      out_last_q  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      n_match     <= '0;
      n_mismatch  <= '0;
      n_indel     <= '0;
      score       <= '0;
    end else begin
      score <= score_n;
      case (state)
        ST_IDLE: begin
          if (tb_valid) begin
            if (tb_coord != START_COORD) err <= 1'b1;
            state <= (tb_coord == '0) ? ST_EMIT : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (tb_valid) begin
            if (tb_coord == '0) begin
              state <= ST_EMIT;
            end else if (full) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_EMIT: begin
          if (last_xfer) begin
            out_valid_q <= 1'b0;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else if (pop) begin
            out_valid_q <= 1'b1;
            out_c1_q    <= c1_n;
            out_c2_q    <= c2_n;
            out_gap1_q  <= g1_n;
            out_gap2_q  <= g2_n;
            out_op_q    <= op_n;
            out_last_q  <= (count == CNTW'(1));
            prev_x      <= cx;
            prev_y      <= cy;
            first_pop   <= 1'b0;
            case (op_n)
              OP_MATCH:    n_match    <= sat_inc(n_match);
              OP_MISMATCH: n_mismatch <= sat_inc(n_mismatch);
              OP_GAP:      n_indel    <= sat_inc(n_indel);
              default:     err        <= 1'b1;
            endcase
          end else if (load) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_traceback_formatter.sv
// Directed bench for traceback_formatter with LENGTH=4: vector table plus corner sequences.
module tb_traceback_formatter;
  localparam int L = 4;

  typedef struct packed {
    logic [1:0] c1;
    logic [1:0] c2;
    logic       g1;
    logic       g2;
    logic [1:0] op;
    logic       last;
  } col_t;

  typedef struct {
    logic [7:0]        s1;
    logic [7:0]        s2;
    int                nw;
    logic [7:0][15:0]  words;
    int                nc;
    col_t [7:0]        cols;
    int                nm, nx, ni, sc, er;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset, clear, tb_valid;
  logic [7:0]        s1, s2;
  logic [15:0]       tb_coord;
  logic              done, err;
  logic [8:0]        n_match, n_mismatch, n_indel;
  logic signed [15:0] score;

  traceback_formatter_if #(.CWIDTH(2)) col ();

  traceback_formatter #(.LENGTH(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .s1         (s1),
    .s2         (s2),
    .tb_valid   (tb_valid),
    .tb_coord   (tb_coord),
    .col        (col),
    .done       (done),
    .err        (err),
    .n_match    (n_match),
    .n_mismatch (n_mismatch),
    .n_indel    (n_indel),
    .score      (score)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[4];
  bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [15:0] wd(input int x, input int y);
    return {8'(x), 8'(y)};
  endfunction

  function automatic col_t mk(input int c1, input int c2, input int g1, input int g2,
                              input int op, input int last);
    col_t c;
    c.c1 = 2'(c1); c.c2 = 2'(c2); c.g1 = 1'(g1); c.g2 = 1'(g2);
    c.op = 2'(op); c.last = 1'(last);
    return c;
  endfunction

  function automatic col_t cur_col();
    return {col.out_c1, col.out_c2, col.out_gap1, col.out_gap2, col.out_op, col.out_last};
  endfunction

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic drive_stream(input int k);
    s1 = vecs[k].s1;
    s2 = vecs[k].s2;
    for (int i = 0; i < vecs[k].nw; i++) begin
      @(negedge clk); tb_valid = 1'b1; tb_coord = vecs[k].words[i];
    end
    @(negedge clk); tb_valid = 1'b0; tb_coord = '0;
  endtask

  // Accept n columns, comparing each transfer and holding-stability during stalls
  task automatic collect(input int k, input int n, input bit bp, output int first_cyc);
    int   idx = 0;
    int   cyc = 0;
    bit   stalled = 1'b0;
    bit   rdy;
    col_t saved;
    first_cyc = -1;
    while (idx < n && cyc < 100) begin
      @(negedge clk); cyc++;
      rdy = bp ? pat[(cyc - 1) % 4] : 1'b1;
      col.out_ready = rdy;
      if (stalled) check("stall_hold", int'(cur_col()), int'(saved));
      if (col.out_valid && first_cyc < 0) first_cyc = cyc;
      if (col.out_valid && rdy) begin
        check($sformatf("v%0d_col%0d", k, idx), int'(cur_col()), int'(vecs[k].cols[idx]));
        idx++;
        stalled = 1'b0;
      end else if (col.out_valid) begin
        stalled = 1'b1;
        saved   = cur_col();
      end else begin
        stalled = 1'b0;
      end
    end
    check("cols_seen", idx, n);
  endtask

  task automatic final_checks(input int k);
    @(negedge clk);
    col.out_ready = 1'b1;
    check($sformatf("v%0d_done", k), int'(done), 1);
    check($sformatf("v%0d_err", k), int'(err), vecs[k].er);
    check($sformatf("v%0d_n_match", k), int'(n_match), vecs[k].nm);
    check($sformatf("v%0d_n_mismatch", k), int'(n_mismatch), vecs[k].nx);
    check($sformatf("v%0d_n_indel", k), int'(n_indel), vecs[k].ni);
    check($sformatf("v%0d_score", k), int'(score), vecs[k].sc);
    check($sformatf("v%0d_valid_low", k), int'(col.out_valid), 0);
  endtask

  task automatic run_vec(input int k, input bit bp);
    int first;
    pulse_clear();
    drive_stream(k);
    check($sformatf("v%0d_latency_low", k), int'(col.out_valid), 0);
    collect(k, vecs[k].nc, bp, first);
    check($sformatf("v%0d_first_col_cycle", k), first, 1);
    final_checks(k);
  endtask

  initial begin
    logic [15:0] ovf[8];
    int          first;

    // 0: gaps and a mismatch
    vecs[0].s1 = 8'h1B; vecs[0].s2 = 8'h6C; vecs[0].nw = 5;
    vecs[0].words[0] = wd(3, 3); vecs[0].words[1] = wd(2, 3); vecs[0].words[2] = wd(1, 2);
    vecs[0].words[3] = wd(0, 1); vecs[0].words[4] = wd(0, 0);
    vecs[0].nc = 5;
    vecs[0].cols[0] = mk(0, 1, 0, 0, 1, 0);
    vecs[0].cols[1] = mk(1, 0, 0, 1, 2, 0);
    vecs[0].cols[2] = mk(2, 2, 0, 0, 0, 0);
    vecs[0].cols[3] = mk(3, 3, 0, 0, 0, 0);
    vecs[0].cols[4] = mk(0, 0, 1, 0, 2, 1);
    vecs[0].nm = 2; vecs[0].nx = 1; vecs[0].ni = 2; vecs[0].sc = -1; vecs[0].er = 0;
    // 1: all matches
    vecs[1].s1 = 8'h1B; vecs[1].s2 = 8'h1B; vecs[1].nw = 4;
    vecs[1].words[0] = wd(3, 3); vecs[1].words[1] = wd(2, 2);
    vecs[1].words[2] = wd(1, 1); vecs[1].words[3] = wd(0, 0);
    vecs[1].nc = 4;
    vecs[1].cols[0] = mk(0, 0, 0, 0, 0, 0);
    vecs[1].cols[1] = mk(1, 1, 0, 0, 0, 0);
    vecs[1].cols[2] = mk(2, 2, 0, 0, 0, 0);
    vecs[1].cols[3] = mk(3, 3, 0, 0, 0, 1);
    vecs[1].nm = 4; vecs[1].nx = 0; vecs[1].ni = 0; vecs[1].sc = 4; vecs[1].er = 0;
    // 2: stream not starting at the corner
    vecs[2].s1 = 8'h1B; vecs[2].s2 = 8'h1B; vecs[2].nw = 3;
    vecs[2].words[0] = wd(2, 2); vecs[2].words[1] = wd(1, 1); vecs[2].words[2] = wd(0, 0);
    vecs[2].nc = 3;
    vecs[2].cols[0] = mk(0, 0, 0, 0, 0, 0);
    vecs[2].cols[1] = mk(1, 1, 0, 0, 0, 0);
    vecs[2].cols[2] = mk(2, 2, 0, 0, 0, 1);
    vecs[2].nm = 3; vecs[2].nx = 0; vecs[2].ni = 0; vecs[2].sc = 3; vecs[2].er = 1;
    // 3: illegal step (1,1)->(3,3)
    vecs[3].s1 = 8'h1B; vecs[3].s2 = 8'h1B; vecs[3].nw = 3;
    vecs[3].words[0] = wd(3, 3); vecs[3].words[1] = wd(1, 1); vecs[3].words[2] = wd(0, 0);
    vecs[3].nc = 3;
    vecs[3].cols[0] = mk(0, 0, 0, 0, 0, 0);
    vecs[3].cols[1] = mk(1, 1, 0, 0, 0, 0);
    vecs[3].cols[2] = mk(0, 0, 1, 1, 3, 1);
    vecs[3].nm = 2; vecs[3].nx = 0; vecs[3].ni = 0; vecs[3].sc = 2; vecs[3].er = 1;

    reset = 1'b1; clear = 1'b0; tb_valid = 1'b0; tb_coord = '0;
    s1 = '0; s2 = '0; col.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", int'(col.out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_n_match", int'(n_match), 0);
    check("rst_score", int'(score), 0);

    for (int k = 0; k < 4; k++) run_vec(k, 1'b0);

    // Trailing (0,0) words after done are ignored
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); tb_valid = 1'b1; tb_coord = '0;
    end
    @(negedge clk); tb_valid = 1'b0;
    check("trail_done", int'(done), 1);
    check("trail_n_match", int'(n_match), 2);
    check("trail_score", int'(score), 2);
    check("trail_valid", int'(col.out_valid), 0);
    pulse_clear();
    check("clr_done", int'(done), 0);
    check("clr_err", int'(err), 0);
    check("clr_n_match", int'(n_match), 0);
    check("clr_score", int'(score), 0);
    run_vec(0, 1'b0);

    // Backpressure with ready pattern 1,0,0,1
    run_vec(1, 1'b1);

    // Overflow: 8 non-terminal words into a 7-entry stack
    ovf = '{wd(3, 3), wd(3, 2), wd(3, 1), wd(3, 0), wd(2, 0), wd(1, 0), wd(1, 0), wd(1, 0)};
    pulse_clear();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); tb_valid = 1'b1; tb_coord = ovf[i];
    end
    @(negedge clk); tb_valid = 1'b0; tb_coord = '0;
    check("ovf_err", int'(err), 1);
    check("ovf_done", int'(done), 1);
    repeat (4) @(negedge clk);
    check("ovf_no_output", int'(col.out_valid), 0);

    // Reset in the middle of EMIT
    pulse_clear();
    drive_stream(1);
    collect(1, 2, 1'b0, first);
    @(negedge clk);
    check("pre_rst_n_match", int'(n_match), 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_valid", int'(col.out_valid), 0);
    check("mid_rst_n_match", int'(n_match), 0);
    check("mid_rst_done", int'(done), 0);
    run_vec(1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
